// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead add/subtract unit.
package adder_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   function automatic int slice_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead block: every internal carry is a flat sum of products.
module cla_group #(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             c_in,
   output logic [GROUP-1:0] s,
   output logic             pg,
   output logic             gg
);

   logic [GROUP-1:0] g;
   logic [GROUP-1:0] p;
   logic [GROUP-1:0] carry;
   // gen_pre[i]/prop_pre[i]: generate/propagate of bits [i-1:0], independent of c_in
   logic [GROUP:0]   gen_pre;
   logic [GROUP:0]   prop_pre;

   assign g = a & b;
   assign p = a | b;

   always_comb begin
      logic acc_g;
      logic acc_p;
      logic term;
      gen_pre  = '0;
      prop_pre = '0;
      for (int i = 0; i <= GROUP; i++) begin
         acc_p = 1'b1;
         acc_g = 1'b0;
         for (int j = 0; j < i; j++) acc_p = acc_p & p[j];
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int k = j + 1; k < i; k++) term = term & p[k];
            acc_g = acc_g | term;
         end
         gen_pre[i]  = acc_g;
         prop_pre[i] = acc_p;
      end
   end

   for (genvar gi = 0; gi < GROUP; gi++) begin : g_carry
      assign carry[gi] = gen_pre[gi] | (prop_pre[gi] & c_in);
   end

   assign s  = a ^ b ^ carry;
   assign pg = prop_pre[GROUP];
   assign gg = gen_pre[GROUP];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract: one slice per stage, carry registered between stages,
// valid/ready handshake with full backpressure and bubble collapse.
module pipelined_cla_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int GROUP  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow,
   output logic             zero
);

   localparam int SLICE = slice_width(WIDTH, STAGES);
   localparam int GPS   = SLICE / GROUP;

   if (STAGES < 1 || (WIDTH % (STAGES * GROUP)) != 0) begin : g_bad_params
      $error("pipelined_cla_adder: WIDTH must be a multiple of STAGES*GROUP");
   end

   // Unfinished operand bits ride along (skew); finished sum bits accumulate (deskew).
   typedef struct packed {
      logic [WIDTH-1:0] a_rem;
      logic [WIDTH-1:0] bx_rem;
      logic [WIDTH-1:0] sum_done;
      logic             carry;
      logic             a_msb;
      logic             bx_msb;
   } stage_payload_t;

   logic [WIDTH-1:0]  bx;
   logic              carry0;
   stage_payload_t    stage_in  [STAGES];
   stage_payload_t    stage_nxt [STAGES];
   stage_payload_t    pay_reg   [STAGES];
   logic [STAGES-1:0] valid_reg;
   logic [STAGES-1:0] advance;
   logic [STAGES-1:0] load;
   logic [STAGES-1:0] feed_valid;
   logic              overflow_reg;
   logic              zero_reg;
   logic              overflow_next;
   logic              zero_next;
   stage_payload_t    last_next;

   assign bx     = (sub == OP_SUB) ? ~b : b;
   assign carry0 = (sub == OP_SUB) ? ~c_in : c_in;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [SLICE-1:0] slice_sum;
      logic [GPS-1:0]   grp_pg;
      logic [GPS-1:0]   grp_gg;
      logic [GPS-1:0]   grp_cin;
      logic             slice_cout;
      stage_payload_t   nxt;

      if (gi == 0) begin : g_head
         assign stage_in[gi]   = '{a_rem: a, bx_rem: bx, sum_done: '0, carry: carry0,
                                   a_msb: a[WIDTH-1], bx_msb: bx[WIDTH-1]};
         assign feed_valid[gi] = in_valid & in_ready;
      end else begin : g_feed
         assign stage_in[gi]   = pay_reg[gi-1];
         assign feed_valid[gi] = valid_reg[gi-1];
      end

      if (gi == STAGES - 1) begin : g_last
         assign advance[gi] = valid_reg[gi] & out_ready;
      end else begin : g_mid
         assign advance[gi] = valid_reg[gi] & load[gi+1];
      end
      assign load[gi] = ~valid_reg[gi] | advance[gi];

      for (genvar gj = 0; gj < GPS; gj++) begin : g_group
         cla_group #(.GROUP(GROUP)) u_group (
            .a    (stage_in[gi].a_rem[gi*SLICE + gj*GROUP +: GROUP]),
            .b    (stage_in[gi].bx_rem[gi*SLICE + gj*GROUP +: GROUP]),
            .c_in (grp_cin[gj]),
            .s    (slice_sum[gj*GROUP +: GROUP]),
            .pg   (grp_pg[gj]),
            .gg   (grp_gg[gj])
         );
      end

      // Second-level lookahead: each group carry-in straight from the slice carry-in.
      always_comb begin
         logic acc;
         logic term;
         grp_cin    = '0;
         slice_cout = 1'b0;
         for (int j = 0; j <= GPS; j++) begin
            acc = stage_in[gi].carry;
            for (int m = 0; m < j; m++) acc = acc & grp_pg[m];
            for (int m = 0; m < j; m++) begin
               term = grp_gg[m];
               for (int n = m + 1; n < j; n++) term = term & grp_pg[n];
               acc = acc | term;
            end
            if (j < GPS) grp_cin[j] = acc;
            else         slice_cout = acc;
         end
      end

      always_comb begin
         nxt = stage_in[gi];
         nxt.sum_done[gi*SLICE +: SLICE] = slice_sum;
         nxt.carry = slice_cout;
      end
      assign stage_nxt[gi] = nxt;
   end

   assign last_next     = stage_nxt[STAGES-1];
   assign overflow_next = (last_next.a_msb == last_next.bx_msb) &
                          (last_next.sum_done[WIDTH-1] != last_next.a_msb);
   assign zero_next     = ~|last_next.sum_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg    <= '0;
         overflow_reg <= 1'b0;
         zero_reg     <= 1'b0;
         for (int k = 0; k < STAGES; k++) pay_reg[k] <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               valid_reg[k] <= feed_valid[k];
               if (feed_valid[k]) pay_reg[k] <= stage_nxt[k];
            end
         end
         if (load[STAGES-1] && feed_valid[STAGES-1]) begin
            overflow_reg <= overflow_next;
            zero_reg     <= zero_next;
         end
      end
   end

   assign in_ready  = rst_n & load[0];
   assign out_valid = valid_reg[STAGES-1];
   assign sum       = pay_reg[STAGES-1].sum_done;
   assign c_out     = pay_reg[STAGES-1].carry;
   assign overflow  = overflow_reg;
   assign zero      = zero_reg;

endmodule
